spart_driver: RTL

//  Bus master that sits directly upstream of the SPART on its CPU-side port (iocs/iorw/ioaddr/databus).

---
 rtl/spart_driver_if.sv | 33 +++
 rtl/spart_driver.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spart_driver_if.sv
// spart_driver_if
//   Control/status side of the SPART CPU port as seen by its bus master.
//   The 8-bit databus is a true tri-state line and is carried as a plain
//   inout port on the modules that share it, not inside this interface.
//
//   iocs    chip select, one-cycle pulse per access   (master -> SPART)
//   iorw    1 = read, 0 = write                       (master -> SPART)
//   ioaddr  00 data, 10 divisor low, 11 divisor high  (master -> SPART)
//   rda     receive data available                    (SPART -> master)
//   tbr     transmit buffer ready                     (SPART -> master)
interface spart_driver_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (
        output iocs,
        output iorw,
        output ioaddr,
        input  rda,
        input  tbr
    );

    modport slave (
        input  iocs,
        input  iorw,
        input  ioaddr,
        output rda,
        output tbr
    );
endinterface

// File: rtl/spart_driver.sv
// spart_driver
//   Bus master sitting in front of the SPART CPU port. After reset it writes
//   the baud divisor selected by br_cfg, then echoes every received byte back
//   to the transmitter. Whenever br_cfg changes, the divisor is reprogrammed
//   once the driver is back in IDLE (an echo in flight always completes first).
//
//   Optional build macro: SPART_DRV_UPCASE_EN
//     defined   : bytes 'a'..'z' are transmitted as 'A'..'Z'
//     undefined : bytes are echoed verbatim (no case logic exists)
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   br_cfg   baud select 00=4800 01=9600 10=19200 11=38400 (asynchronous input)
//   bus      spart_driver_if.master: iocs/iorw/ioaddr out, rda/tbr in
//   databus  8-bit tri-state data bus, driven only while iorw == 0
//   rx_cnt   number of bytes echoed, wraps 255 -> 0
//
// State      | meaning
// -----------+-----------------------------------------------------------
// INIT       | one cycle after reset, latch synchronized baud select
// DB_LO      | write divisor low byte  (ioaddr 10)
// DB_HI      | write divisor high byte (ioaddr 11)
// IDLE       | wait for baud change (first) or rda
// READ       | read received byte      (ioaddr 00), captured at end of cycle
// WAIT_TBR   | hold byte until the transmitter is ready
// WRITE      | write byte back         (ioaddr 00), count it
module spart_driver #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     br_cfg,
    spart_driver_if.master bus,
    inout  wire  [7:0]     databus,
    output logic [7:0]     rx_cnt
);

    localparam logic [15:0] DIV_4800  = 16'(CLK_HZ / (OVERSAMPLE * 4800));
    localparam logic [15:0] DIV_9600  = 16'(CLK_HZ / (OVERSAMPLE * 9600));
    localparam logic [15:0] DIV_19200 = 16'(CLK_HZ / (OVERSAMPLE * 19200));
    localparam logic [15:0] DIV_38400 = 16'(CLK_HZ / (OVERSAMPLE * 38400));

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        DB_LO    = 3'd1,
        DB_HI    = 3'd2,
        IDLE     = 3'd3,
        READ     = 3'd4,
        WAIT_TBR = 3'd5,
        WRITE    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  br_meta, br_s;
    logic [1:0]  br_q, br_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  rx_cnt_d;
    logic        iocs_q, iocs_d;
    logic        iorw_q, iorw_d;
    logic [1:0]  ioaddr_q, ioaddr_d;
    logic [7:0]  dout_q, dout_d;

    function automatic logic [15:0] div_sel(input logic [1:0] sel);
        logic [15:0] d;
        case (sel)
            2'b00:   d = DIV_4800;
            2'b01:   d = DIV_9600;
            2'b10:   d = DIV_19200;
            default: d = DIV_38400;
        endcase
        return d;
    endfunction

`ifdef SPART_DRV_UPCASE_EN
    function automatic logic [7:0] tx_byte(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
    endfunction
`else
    function automatic logic [7:0] tx_byte(input logic [7:0] b);
        return b;
    endfunction
`endif

    // br_cfg comes straight from switches. The synchronizer is left without
    // reset so it keeps tracking the switches while rst is held, which lets
    // INIT pick up a settled value on the first cycle after release.
    always_ff @(posedge clk) begin
        br_meta <= br_cfg;
        br_s    <= br_meta;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= INIT;
            br_q     <= 2'b00;
            data_q   <= 8'h00;
            rx_cnt   <= 8'h00;
            iocs_q   <= 1'b0;
            iorw_q   <= 1'b1;
            ioaddr_q <= 2'b00;
            dout_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            br_q     <= br_d;
            data_q   <= data_d;
            rx_cnt   <= rx_cnt_d;
            iocs_q   <= iocs_d;
            iorw_q   <= iorw_d;
            ioaddr_q <= ioaddr_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        br_d     = br_q;
        data_d   = data_q;
        rx_cnt_d = rx_cnt;

        case (state_q)
            INIT: begin
                br_d    = br_s;
                state_d = DB_LO;
            end
            DB_LO:    state_d = DB_HI;
            DB_HI:    state_d = IDLE;
            IDLE: begin
                if (br_s != br_q) begin
                    br_d    = br_s;
                    state_d = DB_LO;
                end else if (bus.rda) begin
                    state_d = READ;
                end
            end
            READ: begin
                data_d  = databus;
                state_d = WAIT_TBR;
            end
            WAIT_TBR: begin
                if (bus.tbr) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                rx_cnt_d = rx_cnt + 8'd1;
                state_d  = IDLE;
            end
            default:  state_d = INIT;
        endcase
    end

    // Bus outputs are decoded from the next state and registered, so the
    // access pulse lines up exactly with the cycle the FSM spends in that
    // access state. br_d already holds the value being programmed.
    always_comb begin
        iocs_d   = 1'b0;
        iorw_d   = 1'b1;
        ioaddr_d = 2'b00;
        dout_d   = dout_q;

        case (state_d)
            DB_LO: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b10;
                dout_d   = div_sel(br_d)[7:0];
            end
            DB_HI: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b11;
                dout_d   = div_sel(br_d)[15:8];
            end
            READ: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b1;
                ioaddr_d = 2'b00;
            end
            WRITE: begin
                iocs_d   = 1'b1;
                iorw_d   = 1'b0;
                ioaddr_d = 2'b00;
                dout_d   = tx_byte(data_d);
            end
            default: ;
        endcase
    end

    assign bus.iocs   = iocs_q;
    assign bus.iorw   = iorw_q;
    assign bus.ioaddr = ioaddr_q;

    // iorw_q resets to 1, so the driver lets go of the bus as soon as rst falls.
    assign databus = iorw_q ? 8'hzz : dout_q;

endmodule
